bcd_7seg_scan: RTL and testbench
================================

Name: bcd_7seg_scan

Overview:
- Downstream consumer of the four BCD digits (thousands/hundreds/tens/ones) from the binary-to-BCD converter.
- Latches the digits on a load strobe and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Supports optional leading-zero blanking, an "Err" indication for calculator overflow, and a global blank.
- All outputs are registered.

Parameters:
- PRESCALE, 16'd50000: clk cycles per digit slot; legal range 1..65535. The bench uses 4.
- BLANK_LZ, 1: 1 = suppress leading zeros on digits 3..1; 0 = always show all four digits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- load  in  1  one-cycle strobe; captures dig1000..dig1 and err.
- dig1000  in  4  thousands BCD digit (display position 3, leftmost).
- dig100  in  4  hundreds BCD digit (position 2).
- dig10  in  4  tens BCD digit (position 1).
- dig1  in  4  ones BCD digit (position 0, rightmost).
- err  in  1  overflow flag; sampled only on load.
- blank  in  1  level; 1 turns the whole display off.
- seg  out  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
- an  out  4  active-low anodes, an[i] drives position i.
- dp  out  1  active-low decimal point; constant 1 (off) in this revision.

Behaviour:
- Reset (rst=0 at an edge):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Digit latches=0, err latch=0, prescaler=0, scan index=0.
  - Reset asserted mid-scan aborts the scan immediately; the first slot after release is index 0.
- Prescaler:
  - 16-bit counter, 0..PRESCALE-1. Wraps to 0 on tick.
  - tick is asserted in the cycle the count equals PRESCALE-1.
- Scan index:
  - 2-bit; increments on tick and wraps 3->0.
  - Order is position 0,1,2,3, so each position is held for PRESCALE cycles.
- Load:
  - On load=1, the digit and err latches update at that edge.
  - Inputs are ignored when load=0.
  - load coincident with tick: both the latch update and the index advance occur.
- Output register timing:
  - At every edge, an/seg are computed from the pre-edge index, latches and blank, giving one cycle of latency.
  - A load or index change at edge k is visible on seg/an after edge k+1.
- Anode: an = ~(1<<index), except when the slot is blanked, in which case an=4'b1111 and seg=7'b1111111.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (invalid BCD) = 0111111 (dash).
- Leading-zero blanking (BLANK_LZ=1, err latch=0):
  - Position 3 is blanked if dig1000==0.
  - Position 2 is blanked if it and all higher digits are 0.
  - Position 1 is blanked if it and all higher digits are 0.
  - Position 0 is never blanked, so a value of 0 shows a single "0".
  - A nonzero invalid digit (>9) counts as nonzero.
- Err (err latch=1): overrides the digits.
  - Position 3='E'=0000110.
  - Positions 2 and 1='r'=0101111.
  - Position 0 is blanked.
- Blank:
  - blank=1 forces an=4'b1111 and seg=7'b1111111 at the next edge, regardless of other state.
  - Prescaler and index keep running. Latches are unaffected.
- Priority: reset > blank > err > slot blanking > digit decode.

Test Plan (PRESCALE=4):
1. Reset and hold: rst=0 for 3 clks, with load=1 and digits 9 -> an=1111, seg=1111111, dp=1 throughout. After release with no load: position 0 shows "0" (an=1110, seg=1000000) for 4 clks; positions 1..3 give an=1111.
2. Full value: load 1,1,1,1 (decimal 1111) -> an cycles 1110,1101,1011,0111, 4 clks each, with seg=1111001 every slot. The new seg appears exactly 1 clk after the load edge.
3. Leading-zero blanking:
   - Load 0,0,4,2 -> slot0 an=1110 seg=0100100; slot1 an=1101 seg=0011001; slots 2,3 an=1111.
   - Load 0,1,0,0 (decimal 100) -> slots 0,1 show "0"; slot2 shows 1111001; slot3 is blank.
   - With BLANK_LZ=0, load 0,0,4,2 -> slots 2,3 show 1000000.
4. Err: load with err=1 and digits 1,2,3,4 -> slot3 seg=0000110, slots 2,1 seg=0101111, slot0 an=1111. Then load with err=0 and digits 5,6,7,8 -> normal decode resumes on the next slot.
5. Invalid digit and blank:
   - Load dig10=4'hA -> slot1 seg=0111111.
   - Assert blank for 6 clks -> an=1111 throughout. On release the index continues from its running value, not from 0.
6. Simultaneous and mid-operation events:
   - load coincident with tick -> the next slot shows the new data and the index advances.
   - rst=0 asserted during slot 2 -> next edge an=1111, seg=1111111, latches=0.
   - After release, the first active slot is position 0.

Source files
------------

// File: rtl/bcd_7seg_scan.sv
// Four-digit common-anode 7-segment scanner for BCD digits from the binary-to-BCD converter.
// Latches digits and an overflow flag on a load strobe; every output is registered.
module bcd_7seg_scan #(
    parameter logic [15:0] PRESCALE = 16'd50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] dig1000,
    input  logic [3:0] dig100,
    input  logic [3:0] dig10,
    input  logic [3:0] dig1,
    input  logic       err,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    // Active-low gfedcba patterns.
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_R   = 7'b0101111;

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [3:0]  d3, d2, d1, d0;
    logic        err_q;

    logic        tick;
    logic [3:0]  cur_dig;
    logic [6:0]  slot_seg;
    logic        slot_on;
    logic        z3, z2, z1;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = (cnt == PRESCALE - 16'd1);

    // load is a bare one-cycle strobe with no back-pressure: whatever sits on
    // the digit/err inputs at a rising edge with load=1 is captured, else ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= 16'd0;
            idx   <= 2'd0;
            d3    <= 4'd0;
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
            err_q <= 1'b0;
            an    <= 4'b1111;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            cnt <= tick ? 16'd0 : cnt + 16'd1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                d3    <= dig1000;
                d2    <= dig100;
                d1    <= dig10;
                d0    <= dig1;
                err_q <= err;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= 1'b1;
        end
    end

    // A position is a leading zero only if it and every position to its left are zero.
    assign z3 = (d3 == 4'd0);
    assign z2 = z3 && (d2 == 4'd0);
    assign z1 = z2 && (d1 == 4'd0);

    always_comb begin
        cur_dig  = d0;
        slot_seg = SEG_OFF;
        slot_on  = 1'b1;
        an_nxt   = 4'b1111;
        seg_nxt  = SEG_OFF;

        case (idx)
            2'd0:    cur_dig = d0;
            2'd1:    cur_dig = d1;
            2'd2:    cur_dig = d2;
            default: cur_dig = d3;
        endcase

        if (err_q) begin
            case (idx)
                2'd3:       slot_seg = SEG_E;
                2'd2, 2'd1: slot_seg = SEG_R;
                default:    slot_on  = 1'b0;
            endcase
        end else begin
            slot_seg = decode(cur_dig);
            if (BLANK_LZ) begin
                case (idx)
                    2'd3:    slot_on = !z3;
                    2'd2:    slot_on = !z2;
                    2'd1:    slot_on = !z1;
                    default: slot_on = 1'b1;
                endcase
            end
        end

        if (!blank && slot_on) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = slot_seg;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan at PRESCALE=4; a second instance runs with leading-zero blanking off.
// Loads are issued on the index-wrap edge so each frame starts cleanly at position 0.
module tb_bcd_7seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] dig1000, dig100, dig10, dig1;
    logic       err;
    logic       blank;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan #(.PRESCALE(16'd4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load),
        .dig1000(dig1000), .dig100(dig100), .dig10(dig10), .dig1(dig1),
        .err(err), .blank(blank), .seg(seg_a), .an(an_a), .dp(dp_a)
    );

    bcd_7seg_scan #(.PRESCALE(16'd4), .BLANK_LZ(1'b0)) dut_nlz (
        .clk(clk), .rst(rst), .load(load),
        .dig1000(dig1000), .dig100(dig100), .dig10(dig10), .dig1(dig1),
        .err(err), .blank(blank), .seg(seg_b), .an(an_b), .dp(dp_b)
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; sample 1 time unit after the edge and drop any load strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                            input logic [3:0] o, input logic e);
        dig1000 = t; dig100 = h; dig10 = te; dig1 = o; err = e; load = 1'b1;
    endtask

    task automatic slot_chk(input string tag, input bit nlz, input int pos, input bit shown,
                            input logic [6:0] s, input int n);
        logic [3:0] ea;
        logic [6:0] es;
        ea = 4'b1111;
        if (shown) ea[pos] = 1'b0;
        es = shown ? s : 7'b1111111;
        for (int i = 0; i < n; i++) begin
            tick();
            if (nlz) begin
                check($sformatf("%s_p%0d_an", tag, pos), {3'b000, an_b}, {3'b000, ea});
                check($sformatf("%s_p%0d_seg", tag, pos), seg_b, es);
            end else begin
                check($sformatf("%s_p%0d_an", tag, pos), {3'b000, an_a}, {3'b000, ea});
                check($sformatf("%s_p%0d_seg", tag, pos), seg_a, es);
                check($sformatf("%s_p%0d_dp", tag, pos), {6'd0, dp_a}, 7'd1);
            end
        end
    endtask

    // Checks one full frame; optionally loads new data on the final (wrap) edge.
    task automatic frame_chk(input string tag, input bit nlz, input logic [3:0] mask,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input bit do_load, input logic [3:0] t, input logic [3:0] h,
                             input logic [3:0] te, input logic [3:0] o, input logic e);
        slot_chk(tag, nlz, 0, mask[0], s0, 4);
        slot_chk(tag, nlz, 1, mask[1], s1, 4);
        slot_chk(tag, nlz, 2, mask[2], s2, 4);
        slot_chk(tag, nlz, 3, mask[3], s3, 3);
        if (do_load) set_load(t, h, te, o, e);
        slot_chk(tag, nlz, 3, mask[3], s3, 1);
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; blank = 1'b0; err = 1'b0;
        dig1000 = 4'd9; dig100 = 4'd9; dig10 = 4'd9; dig1 = 4'd9;

        // Reset held with a pending load: display stays dark, load is ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_an", {3'b000, an_a}, 7'b0001111);
            check("rst_seg", seg_a, 7'b1111111);
            check("rst_dp", {6'd0, dp_a}, 7'd1);
            check("rst_nlz_seg", seg_b, 7'b1111111);
        end
        rst = 1'b1; load = 1'b0;
        dig1000 = 4'd0; dig100 = 4'd0; dig10 = 4'd0; dig1 = 4'd0;

        frame_chk("zero", 0, 4'b0001, 7'b1000000, 7'b0, 7'b0, 7'b0,
                  1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        frame_chk("v1111", 0, 4'b1111, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001,
                  1, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
        frame_chk("v42", 0, 4'b0011, 7'b0100100, 7'b0011001, 7'b0, 7'b0,
                  1, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        frame_chk("v100", 0, 4'b0111, 7'b1000000, 7'b1000000, 7'b1111001, 7'b0,
                  1, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
        frame_chk("nlz42", 1, 4'b1111, 7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000,
                  1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        frame_chk("err", 0, 4'b1110, 7'b0, 7'b0101111, 7'b0101111, 7'b0000110,
                  1, 4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
        frame_chk("v5678", 0, 4'b1111, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
                  1, 4'd0, 4'd0, 4'hA, 4'd3, 1'b0);
        frame_chk("inv", 0, 4'b0011, 7'b0110000, 7'b0111111, 7'b0, 7'b0,
                  0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Global blank for 6 clocks; the scan keeps running underneath.
        blank = 1'b1;
        slot_chk("blank", 0, 0, 0, 7'b0, 6);
        blank = 1'b0;
        slot_chk("unblank", 0, 1, 1, 7'b0111111, 2);
        slot_chk("unblank", 0, 2, 0, 7'b0, 4);
        slot_chk("unblank", 0, 3, 0, 7'b0, 3);
        set_load(4'd9, 4'd8, 4'd7, 4'd6, 1'b0);
        slot_chk("unblank", 0, 3, 0, 7'b0, 1);

        // Reset arrives mid-way through position 2.
        slot_chk("v9876", 0, 0, 1, 7'b0000010, 4);
        slot_chk("v9876", 0, 1, 1, 7'b1111000, 4);
        slot_chk("v9876", 0, 2, 1, 7'b0000000, 2);
        rst = 1'b0;
        slot_chk("midrst", 0, 0, 0, 7'b0, 2);
        rst = 1'b1;
        frame_chk("postrst", 0, 4'b0001, 7'b1000000, 7'b0, 7'b0, 7'b0,
                  0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
